// File: rtl/cdc_pkg.sv
// Shared types and constants for the clock-domain-crossing handshake blocks.
//   hs_rx_state_t   : receive-side handshake FSM encoding
//   MIN_SYNC_STAGES : shallowest synchroniser depth that is accepted
package cdc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_ACK  = 2'd2
  } hs_rx_state_t;

  localparam int MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/cdc_sync_bit.sv
// N-stage single-bit synchroniser with asynchronous active-high reset.
// Ports:
//   clk_i : destination clock
//   rst_i : asynchronous active-high reset, loads RESET_VAL into every stage
//   d_i   : asynchronous input bit
//   q_o   : synchronised bit (last stage)
module cdc_sync_bit
  import cdc_pkg::*;
#(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  if (STAGES < MIN_SYNC_STAGES) begin : g_bad_stages
    $error("cdc_sync_bit: STAGES must be >= %0d", MIN_SYNC_STAGES);
  end

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= {STAGES{RESET_VAL}};
    else       sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_hs_rx.sv
// Destination endpoint of a 4-phase req/ack crossing. Synchronises REQ_i,
// captures DATA_i once per handshake, offers it on a valid/ready interface
// and returns ACK_o once the word has been taken downstream.
// Ports:
//   CLK_i, RST_i  : destination clock, async active-high reset
//   REQ_i, DATA_i : source request (asynchronous) and held data word
//   ACK_o         : registered acknowledge back to the source
//   VALID_o, READY_i, DATA_o : downstream valid/ready word interface
//   ERR_o         : sticky flag, source dropped REQ before it was acked
//   XFER_CNT_o    : wrapping count of words accepted downstream
//
// state   | meaning
// IDLE    | waiting for synchronised request, ACK low, nothing offered
// HOLD    | word captured and offered downstream, waiting for READY_i
// ACK     | word taken, ACK high until the source drops its request
module cdc_hs_rx
  import cdc_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic              CLK_i,
  input  logic              RST_i,
  input  logic              REQ_i,
  input  logic [DATA_W-1:0] DATA_i,
  output logic              ACK_o,
  output logic              VALID_o,
  input  logic              READY_i,
  output logic [DATA_W-1:0] DATA_o,
  output logic              ERR_o,
  output logic [CNT_W-1:0]  XFER_CNT_o
);

  if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_stages
    $error("cdc_hs_rx: SYNC_STAGES must be >= %0d", MIN_SYNC_STAGES);
  end

  logic req_s;

  cdc_sync_bit #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b0)
  ) u_req_sync (
    .clk_i (CLK_i),
    .rst_i (RST_i),
    .d_i   (REQ_i),
    .q_o   (req_s)
  );

  hs_rx_state_t      state_q, state_d;
  logic              ack_q, ack_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    valid_d = valid_q;
    err_d   = err_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        ack_d   = 1'b0;
        valid_d = 1'b0;
        if (req_s) begin
          // DATA_i has been stable since before REQ_i rose, so it is safe to
          // sample directly once the request has made it through the chain.
          data_d  = DATA_i;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!req_s) err_d = 1'b1;
        // A withdrawn request still lets the captured word go downstream,
        // but no ack is returned for it.
        if (valid_q && READY_i) begin
          valid_d = 1'b0;
          cnt_d   = cnt_q + CNT_W'(1);
          if (req_s) begin
            ack_d   = 1'b1;
            state_d = ST_ACK;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_ACK: begin
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        ack_d   = 1'b0;
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ACK_o      = ack_q;
  assign VALID_o    = valid_q;
  assign DATA_o     = data_q;
  assign ERR_o      = err_q;
  assign XFER_CNT_o = cnt_q;

endmodule

// File: tb/tb_cdc_hs_rx.sv
// Bench for cdc_hs_rx: directed scenarios drive the source side and push each
// expected word into a queue; a monitor on the falling edge pops and compares
// whenever a word is handed over downstream (VALID_o & READY_i).
module tb_cdc_hs_rx;

  logic       CLK_i = 1'b0;
  logic       src_clk = 1'b0;
  logic       RST_i = 1'b1;
  logic       REQ_i = 1'b0;
  logic [7:0] DATA_i = 8'h00;
  logic       READY_i = 1'b0;
  logic       ACK_o, VALID_o, ERR_o;
  logic [7:0] DATA_o;
  logic [15:0] XFER_CNT_o;

  logic       ack_w4, valid_w4, err_w4;
  logic [7:0] data_w4;
  logic [3:0] cnt_w4;

  int nvec = 0;
  int nerr = 0;
  int exp_cnt = 0;
  bit rand_rdy = 1'b0;
  logic [7:0] exp_q[$];

  cdc_hs_rx #(.DATA_W(8), .SYNC_STAGES(2), .CNT_W(16)) u_dut (
    .CLK_i(CLK_i), .RST_i(RST_i), .REQ_i(REQ_i), .DATA_i(DATA_i),
    .ACK_o(ACK_o), .VALID_o(VALID_o), .READY_i(READY_i), .DATA_o(DATA_o),
    .ERR_o(ERR_o), .XFER_CNT_o(XFER_CNT_o)
  );

  // Same stimulus, narrow counter, to exercise the wrap.
  cdc_hs_rx #(.DATA_W(8), .SYNC_STAGES(2), .CNT_W(4)) u_w4 (
    .CLK_i(CLK_i), .RST_i(RST_i), .REQ_i(REQ_i), .DATA_i(DATA_i),
    .ACK_o(ack_w4), .VALID_o(valid_w4), .READY_i(READY_i), .DATA_o(data_w4),
    .ERR_o(err_w4), .XFER_CNT_o(cnt_w4)
  );

  always #5 CLK_i = ~CLK_i;                        // 100 MHz stand-in for clk_200
  initial begin #3; forever #10 src_clk = ~src_clk; end  // half rate, offset phase

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK_i);
    #1;
  endtask

  task automatic wait_ack(input logic v, input int lim, input string nm);
    int n = 0;
    while (ACK_o !== v && n < lim) begin
      tick(1);
      n++;
    end
    chk(nm, {31'd0, ACK_o}, {31'd0, v});
  endtask

  task automatic xfer_sync(input logic [7:0] d);
    DATA_i = d;
    exp_q.push_back(d);
    REQ_i = 1'b1;
    wait_ack(1'b1, 20, "xfer_ack_rise");
    REQ_i = 1'b0;
    wait_ack(1'b0, 20, "xfer_ack_fall");
  endtask

  // Monitor: pops the scoreboard on every downstream handshake.
  always @(negedge CLK_i) begin
    if (!RST_i && VALID_o === 1'b1 && READY_i === 1'b1) begin
      nvec++;
      if (exp_q.size() == 0) begin
        nerr++;
        $display("FAIL mon_unexpected: got word %0h expected none at %0t", DATA_o, $time);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (DATA_o !== e) begin
          nerr++;
          $display("FAIL mon_data: got %0h expected %0h at %0t", DATA_o, e, $time);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge CLK_i);
      #1;
      if (rand_rdy) READY_i = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset values
    tick(2);
    chk("rst_valid", VALID_o, 0);
    chk("rst_ack", ACK_o, 0);
    chk("rst_err", ERR_o, 0);
    chk("rst_data", DATA_o, 0);
    chk("rst_cnt", XFER_CNT_o, 0);
    RST_i = 1'b0;
    tick(1);

    // 1. Basic transfer: valid at edge 3 for one cycle, ack next edge
    READY_i = 1'b1;
    DATA_i = 8'hA5;
    exp_q.push_back(8'hA5);
    REQ_i = 1'b1;
    tick(2);
    chk("t1_valid_e2", VALID_o, 0);
    tick(1);
    chk("t1_valid_e3", VALID_o, 1);
    chk("t1_data_e3", DATA_o, 8'hA5);
    chk("t1_ack_e3", ACK_o, 0);
    tick(1);
    chk("t1_valid_e4", VALID_o, 0);
    chk("t1_ack_e4", ACK_o, 1);
    REQ_i = 1'b0;
    tick(2);
    chk("t1_ack_fall_e2", ACK_o, 1);
    tick(1);
    chk("t1_ack_fall_e3", ACK_o, 0);
    exp_cnt++;
    chk("t1_cnt", XFER_CNT_o, exp_cnt);
    chk("t1_err", ERR_o, 0);

    // 2. Backpressure
    READY_i = 1'b0;
    DATA_i = 8'h5A;
    exp_q.push_back(8'h5A);
    REQ_i = 1'b1;
    tick(3);
    chk("t2_valid", VALID_o, 1);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("t2_hold_valid", VALID_o, 1);
      chk("t2_hold_data", DATA_o, 8'h5A);
      chk("t2_hold_ack", ACK_o, 0);
    end
    READY_i = 1'b1;
    tick(1);
    chk("t2_accept_valid", VALID_o, 0);
    chk("t2_accept_ack", ACK_o, 1);
    REQ_i = 1'b0;
    wait_ack(1'b0, 10, "t2_ack_fall");
    exp_cnt++;
    chk("t2_cnt", XFER_CNT_o, exp_cnt);

    // 3. Source running on its own clock, random downstream readiness
    rand_rdy = 1'b1;
    for (int w = 1; w <= 4; w++) begin
      @(posedge src_clk);
      DATA_i = 8'(w);
      exp_q.push_back(8'(w));
      @(posedge src_clk);
      REQ_i = 1'b1;
      n = 0;
      while (ACK_o !== 1'b1 && n < 200) begin @(posedge src_clk); n++; end
      chk("t3_ack_rise", ACK_o, 1);
      REQ_i = 1'b0;
      n = 0;
      while (ACK_o !== 1'b0 && n < 200) begin @(posedge src_clk); n++; end
      chk("t3_ack_fall", ACK_o, 0);
    end
    rand_rdy = 1'b0;
    tick(2);
    exp_cnt += 4;
    chk("t3_cnt", XFER_CNT_o, exp_cnt);
    chk("t3_err", ERR_o, 0);
    chk("t3_q_empty", exp_q.size(), 0);

    // 4. Source withdraws during HOLD
    READY_i = 1'b0;
    DATA_i = 8'hC3;
    exp_q.push_back(8'hC3);
    REQ_i = 1'b1;
    tick(3);
    chk("t4_valid", VALID_o, 1);
    REQ_i = 1'b0;
    tick(2);
    chk("t4_err_e2", ERR_o, 0);
    tick(1);
    chk("t4_err_e3", ERR_o, 1);
    chk("t4_valid_held", VALID_o, 1);
    READY_i = 1'b1;
    tick(1);
    chk("t4_valid_drop", VALID_o, 0);
    for (int i = 0; i < 4; i++) begin
      chk("t4_no_ack", ACK_o, 0);
      tick(1);
    end
    chk("t4_no_recapture", VALID_o, 0);
    chk("t4_err_sticky", ERR_o, 1);
    exp_cnt++;
    chk("t4_cnt", XFER_CNT_o, exp_cnt);

    // 5. Reset while holding a word; re-capture after release
    READY_i = 1'b0;
    DATA_i = 8'h3C;
    exp_q.push_back(8'h3C);
    REQ_i = 1'b1;
    tick(3);
    chk("t5_valid", VALID_o, 1);
    #1;
    RST_i = 1'b1;
    #1;
    chk("t5_rst_valid", VALID_o, 0);
    chk("t5_rst_ack", ACK_o, 0);
    chk("t5_rst_err", ERR_o, 0);
    chk("t5_rst_cnt", XFER_CNT_o, 0);
    tick(1);
    RST_i = 1'b0;
    exp_cnt = 0;
    tick(2);
    chk("t5_valid_e2", VALID_o, 0);
    tick(1);
    chk("t5_valid_e3", VALID_o, 1);
    chk("t5_data_e3", DATA_o, 8'h3C);
    READY_i = 1'b1;
    tick(1);
    chk("t5_ack", ACK_o, 1);
    REQ_i = 1'b0;
    wait_ack(1'b0, 10, "t5_ack_fall");
    exp_cnt++;
    chk("t5_cnt", XFER_CNT_o, exp_cnt);

    // 6. Counter wrap on the 4-bit instance
    RST_i = 1'b1;
    tick(1);
    RST_i = 1'b0;
    exp_cnt = 0;
    READY_i = 1'b1;
    tick(1);
    for (int i = 1; i <= 17; i++) begin
      xfer_sync(8'(8'h40 + i));
      exp_cnt++;
      if (i == 15) chk("t6_w4_after15", cnt_w4, 4'hF);
      if (i == 16) chk("t6_w4_after16", cnt_w4, 4'h0);
      if (i == 17) chk("t6_w4_after17", cnt_w4, 4'h1);
    end
    chk("t6_cnt16", XFER_CNT_o, exp_cnt);
    chk("t6_err", ERR_o, 0);
    chk("t6_w4_err", err_w4, 0);

    tick(2);
    chk("end_q_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
